// File: rtl/divide_n_bit_seq.sv
// Multi-cycle restoring divider producing one quotient bit per clock.
// Signed or unsigned per transaction. Valid/ready handshakes on both sides.
module divide_n_bit_seq #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         is_signed_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o,
  output logic         overflow_o,
  output logic         busy_o
);

  localparam int unsigned CntW   = $clog2(N + 1);
  localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
  logic [N-1:0]    quo_q;
  logic [N-1:0]    rem_q;
  logic [N:0]      dvs_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            ovf_q;

  logic            dvd_neg;
  logic            dvs_neg;
  logic [N-1:0]    dvd_mag;
  logic [N:0]      dvs_ext;
  logic [N:0]      dvs_mag;
  logic            ovf_case;
  logic [N:0]      rem_shift;
  logic [N-1:0]    rem_sub;
  logic            fits;
  logic [N-1:0]    quo_next;
  logic [N-1:0]    rem_next;
  logic [N-1:0]    quo_fix;
  logic [N-1:0]    rem_fix;

  always_comb begin
    dvd_neg  = is_signed_i & dividend_i[N-1];
    dvs_neg  = is_signed_i & divisor_i[N-1];
    // N bits hold the dividend magnitude: -2^(N-1) negates to 2^(N-1) read as unsigned.
    dvd_mag  = dvd_neg ? -dividend_i : dividend_i;
    dvs_ext  = {dvs_neg, divisor_i};
    dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
    ovf_case = is_signed_i & (dividend_i == MinNeg) & (divisor_i == '1);

    rem_shift = {rem_q, quo_q[N-1]};
    fits      = (rem_shift >= dvs_q);
    // When the trial fits the difference is below the divisor, so N bits suffice.
    rem_sub   = rem_shift[N-1:0] - dvs_q[N-1:0];
    rem_next  = fits ? rem_sub : rem_shift[N-1:0];
    quo_next  = {quo_q[N-2:0], fits};
    quo_fix   = neg_quo_q ? -quo_next : quo_next;
    rem_fix   = neg_rem_q ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      ovf_q         <= 1'b0;
      in_ready_o    <= 1'b1;
      out_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && in_ready_o) begin
            in_ready_o <= 1'b0;
            overflow_o <= 1'b0;
            if (divisor_i == '0) begin
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
              out_valid_o   <= 1'b1;
              state_q       <= StDone;
            end else begin
              div_by_zero_o <= 1'b0;
              quo_q         <= dvd_mag;
              rem_q         <= '0;
              dvs_q         <= dvs_mag;
              neg_quo_q     <= dvd_neg ^ dvs_neg;
              neg_rem_q     <= dvd_neg;
              ovf_q         <= ovf_case;
              cnt_q         <= CntW'(N);
              busy_o        <= 1'b1;
              state_q       <= StCalc;
            end
          end
        end
        StCalc: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            quotient_o  <= quo_fix;
            remainder_o <= rem_fix;
            overflow_o  <= ovf_q;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_n_bit_seq.sv
// Scoreboard bench for divide_n_bit_seq: an N=8 and an N=16 instance driven by directed steps.
module tb_divide_n_bit_seq;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  logic       n_in_valid, n_in_ready, n_is_signed, n_out_valid, n_out_ready;
  logic       n_dbz, n_ovf, n_busy;
  logic [7:0] n_dividend, n_divisor, n_quotient, n_remainder;

  logic        w_in_valid, w_in_ready, w_is_signed, w_out_valid, w_out_ready;
  logic        w_dbz, w_ovf, w_busy;
  logic [15:0] w_dividend, w_divisor, w_quotient, w_remainder;

  divide_n_bit_seq #(.N(8)) u_dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (n_in_valid),
    .in_ready_o    (n_in_ready),
    .is_signed_i   (n_is_signed),
    .dividend_i    (n_dividend),
    .divisor_i     (n_divisor),
    .out_valid_o   (n_out_valid),
    .out_ready_i   (n_out_ready),
    .quotient_o    (n_quotient),
    .remainder_o   (n_remainder),
    .div_by_zero_o (n_dbz),
    .overflow_o    (n_ovf),
    .busy_o        (n_busy)
  );

  divide_n_bit_seq #(.N(16)) u_dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (w_in_valid),
    .in_ready_o    (w_in_ready),
    .is_signed_i   (w_is_signed),
    .dividend_i    (w_dividend),
    .divisor_i     (w_divisor),
    .out_valid_o   (w_out_valid),
    .out_ready_i   (w_out_ready),
    .quotient_o    (w_quotient),
    .remainder_o   (w_remainder),
    .div_by_zero_o (w_dbz),
    .overflow_o    (w_ovf),
    .busy_o        (w_busy)
  );

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mask_of(input bit w);
    return w ? 16'hFFFF : 16'h00FF;
  endfunction
  function automatic logic [15:0] get_q(input bit w);
    return w ? w_quotient : {8'h00, n_quotient};
  endfunction
  function automatic logic [15:0] get_r(input bit w);
    return w ? w_remainder : {8'h00, n_remainder};
  endfunction
  function automatic logic get_valid(input bit w);
    return w ? w_out_valid : n_out_valid;
  endfunction
  function automatic logic get_ready(input bit w);
    return w ? w_in_ready : n_in_ready;
  endfunction
  function automatic logic get_busy(input bit w);
    return w ? w_busy : n_busy;
  endfunction
  function automatic logic get_dbz(input bit w);
    return w ? w_dbz : n_dbz;
  endfunction
  function automatic logic get_ovf(input bit w);
    return w ? w_ovf : n_ovf;
  endfunction

  // Reference model built on the language's truncating / and %.
  function automatic exp_t model(input bit w, input bit sgn, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t        e;
    int          sa, sd, qi, ri;
    logic [15:0] m;
    logic [15:0] am, bm;
    m  = mask_of(w);
    am = a & m;
    bm = b & m;
    e  = '0;
    if (bm == 16'h0000) begin
      e.q   = m;
      e.r   = am;
      e.dbz = 1'b1;
    end else begin
      if (sgn) begin
        sa = w ? int'($signed(am)) : int'($signed(am[7:0]));
        sd = w ? int'($signed(bm)) : int'($signed(bm[7:0]));
      end else begin
        sa = int'(am);
        sd = int'(bm);
      end
      qi    = sa / sd;
      ri    = sa % sd;
      e.ovf = sgn && (sa == (w ? -32768 : -128)) && (sd == -1);
      e.q   = 16'(qi) & m;
      e.r   = 16'(ri) & m;
    end
    return e;
  endfunction

  task automatic set_in(input bit w, input logic v, input bit sgn, input logic [15:0] a,
                        input logic [15:0] b);
    if (w) begin
      w_in_valid  = v;
      w_is_signed = sgn;
      w_dividend  = a;
      w_divisor   = b;
    end else begin
      n_in_valid  = v;
      n_is_signed = sgn;
      n_dividend  = a[7:0];
      n_divisor   = b[7:0];
    end
  endtask

  task automatic set_out_ready(input bit w, input logic v);
    if (w) w_out_ready = v;
    else n_out_ready = v;
  endtask

  // Called at a falling edge; returns at the falling edge after the acceptance edge.
  task automatic start_op(input bit w, input bit sgn, input logic [15:0] a,
                          input logic [15:0] b, output int acc);
    int t = 0;
    set_in(w, 1'b1, sgn, a, b);
    while (!get_ready(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    checki("accept_wait", t, 0);
    @(posedge clk);
    @(negedge clk);
    acc = int'(cyc);
    // Scramble the inputs; only the values at acceptance may matter.
    set_in(w, 1'b0, ~sgn, ~a, b ^ 16'h0005);
    check1("in_ready_low_after_accept", get_ready(w), 1'b0);
  endtask

  task automatic finish_op(input bit w, input int elat, input int hold);
    int   lat = 1;
    exp_t e;
    while (!get_valid(w) && lat < 40) begin
      check1("busy_during_calc", get_busy(w), 1'b1);
      @(negedge clk);
      lat++;
    end
    checki("latency", lat, elat);
    check1("busy_with_valid", get_busy(w), 1'b0);
    checki("scoreboard_nonempty", int'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '0;
    check16("quotient", get_q(w), e.q);
    check16("remainder", get_r(w), e.r);
    check1("div_by_zero", get_dbz(w), e.dbz);
    check1("overflow", get_ovf(w), e.ovf);
    check1("in_ready_in_done", get_ready(w), 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check1("hold_out_valid", get_valid(w), 1'b1);
      check16("hold_quotient", get_q(w), e.q);
      check16("hold_remainder", get_r(w), e.r);
      check1("hold_in_ready", get_ready(w), 1'b0);
    end
    set_out_ready(w, 1'b1);
    @(negedge clk);
    set_out_ready(w, 1'b0);
    check1("out_valid_dropped", get_valid(w), 1'b0);
    check1("in_ready_after_handshake", get_ready(w), 1'b1);
    check16("quotient_kept", get_q(w), e.q);
    check1("dbz_kept", get_dbz(w), e.dbz);
  endtask

  task automatic do_op(input bit w, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                       input logic eovf, input int hold, output int acc);
    exp_t e;
    e.q   = eq & mask_of(w);
    e.r   = er & mask_of(w);
    e.dbz = edbz;
    e.ovf = eovf;
    sb_q.push_back(e);
    start_op(w, sgn, a & mask_of(w), b & mask_of(w), acc);
    finish_op(w, edbz ? 1 : (w ? 17 : 9), hold);
  endtask

  task automatic reset_mid_calc(input bit w, input bit sgn, input logic [15:0] a,
                                input logic [15:0] b);
    int acc;
    int spur = 0;
    start_op(w, sgn, a & mask_of(w), b & mask_of(w), acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("rst_out_valid", get_valid(w), 1'b0);
    check1("rst_busy", get_busy(w), 1'b0);
    check1("rst_in_ready", get_ready(w), 1'b1);
    check16("rst_quotient", get_q(w), 16'h0000);
    check16("rst_remainder", get_r(w), 16'h0000);
    check1("rst_dbz", get_dbz(w), 1'b0);
    check1("rst_ovf", get_ovf(w), 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (get_valid(w)) spur++;
    end
    checki("no_spurious_valid", spur, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   acc, acc1, acc2;
    exp_t e;
    logic [15:0] ra, rb;
    bit   rs;

    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    n_out_ready = 1'b0;
    w_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_in_ready", n_in_ready, 1'b1);
    check1("reset_out_valid", n_out_valid, 1'b0);
    check1("reset_busy", n_busy, 1'b0);
    check16("reset_quotient", {8'h00, n_quotient}, 16'h0000);
    check16("reset_remainder", {8'h00, n_remainder}, 16'h0000);
    check1("reset_dbz", n_dbz, 1'b0);
    check1("reset_ovf", n_ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 1, 16'(-7), 16'd2, 16'(-3), 16'(-1), 0, 0, 0, acc);
    do_op(0, 0, 16'd200, 16'd7, 16'd28, 16'd4, 0, 0, 0, acc);
    do_op(0, 1, 16'd200, 16'd7, 16'(-8), 16'd0, 0, 0, 0, acc);
    do_op(0, 1, 16'(-128), 16'(-1), 16'h0080, 16'd0, 0, 1, 0, acc);
    do_op(0, 1, 16'(-128), 16'd1, 16'(-128), 16'd0, 0, 0, 0, acc);
    do_op(0, 0, 16'd5, 16'd0, 16'h00FF, 16'd5, 1, 0, 0, acc);
    do_op(0, 1, 16'd9, 16'd3, 16'd3, 16'd0, 0, 0, 0, acc);
    do_op(0, 0, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 5, acc);
    do_op(0, 0, 16'd50, 16'd5, 16'd10, 16'd0, 0, 0, 0, acc1);
    do_op(0, 1, 16'd77, 16'(-3), 16'(-25), 16'd2, 0, 0, 0, acc2);
    checki("throughput", acc2 - acc1, 10);

    reset_mid_calc(0, 0, 16'd77, 16'd3);
    do_op(0, 0, 16'd100, 16'd10, 16'd10, 16'd0, 0, 0, 0, acc);

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      rs = 1'($urandom_range(0, 1));
      e  = model(i >= 6, rs, ra, rb);
      do_op(i >= 6, rs, ra, rb, e.q, e.r, e.dbz, e.ovf, 0, acc);
    end

    reset_mid_calc(1, 1, 16'(-1234), 16'd9);
    do_op(1, 1, 16'(-30000), 16'd7, 16'(-4285), 16'(-5), 0, 0, 0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
